// File: rtl/rat_pkg.sv
// Register alias table package.
// Default configuration constants, the live/snapshot map-entry shape and
// the checkpoint pointer/count types for the default configuration.
// The modules re-derive their own widths from their parameters, so the
// types here describe the standard 32-register / 4-slot build.
package rat_pkg;

    localparam int unsigned RAT_NUM_REGS = 32;
    localparam int unsigned RAT_DATA_W   = 32;
    localparam int unsigned RAT_ROB_W    = 4;
    localparam int unsigned RAT_NREAD    = 2;
    localparam int unsigned RAT_NCKPT    = 4;
    localparam int unsigned RAT_AW       = $clog2(RAT_NUM_REGS);
    localparam int unsigned RAT_CW       = $clog2(RAT_NCKPT);

    typedef struct packed {
        logic                 valid;
        logic [RAT_ROB_W-1:0] tag;
    } map_entry_t;

    typedef logic [RAT_CW-1:0] ckpt_ptr_t;
    typedef logic [RAT_CW:0]   ckpt_cnt_t;

endpackage

// File: rtl/rat_ckpt_store.sv
// Checkpoint store for the register alias table.
// Holds NCKPT Valid/Tag snapshots as a circular FIFO (head, tail, count).
//   take/take_valid/take_tag : write slot[tail] with the post-update map
//   rel                      : free the head slot (oldest branch resolved)
//   restore/restore_id       : free restore_id and all younger slots
//   cm_hit/cm_waddr/cm_tag   : commit tag-match clear applied to occupied slots
//   ckpt_id/full/count       : registered FIFO status
//   snap_valid/snap_tag      : raw snapshot of slot[restore_id], flat
module rat_ckpt_store
    import rat_pkg::*;
#(
    parameter  int unsigned NUM_REGS = RAT_NUM_REGS,
    parameter  int unsigned ROB_W    = RAT_ROB_W,
    parameter  int unsigned NCKPT    = RAT_NCKPT,
    localparam int unsigned AW       = $clog2(NUM_REGS),
    localparam int unsigned CW       = $clog2(NCKPT)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rollback,
    input  logic                      take,
    input  logic                      rel,
    input  logic                      restore,
    input  logic [CW-1:0]             restore_id,
    input  logic [NUM_REGS-1:0]       take_valid,
    input  logic [NUM_REGS*ROB_W-1:0] take_tag,
    input  logic                      cm_hit,
    input  logic [AW-1:0]             cm_waddr,
    input  logic [ROB_W-1:0]          cm_tag,
    output logic [CW-1:0]             ckpt_id,
    output logic                      full,
    output logic [CW:0]               count,
    output logic [NUM_REGS-1:0]       snap_valid,
    output logic [NUM_REGS*ROB_W-1:0] snap_tag
);

    logic [NUM_REGS-1:0] sv [NCKPT];
    logic [ROB_W-1:0]    st [NCKPT][NUM_REGS];
    logic [CW-1:0]       head;
    logic [CW-1:0]       tail;
    logic [CW:0]         cnt;
    logic [NCKPT-1:0]    occ;
    logic                do_take;
    logic                do_rel;

    assign ckpt_id = tail;
    assign count   = cnt;
    assign full    = (cnt == (CW+1)'(NCKPT));
    assign do_take = take && !full;
    assign do_rel  = rel && (cnt != '0);

    // A slot is occupied when its distance from head (mod NCKPT) is below count.
    always_comb begin
        occ = '0;
        for (int unsigned s = 0; s < NCKPT; s++) begin
            occ[s] = {1'b0, CW'(s) - head} < cnt;
        end
    end

    always_comb begin
        snap_valid = sv[restore_id];
        snap_tag   = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            snap_tag[r*ROB_W +: ROB_W] = st[restore_id][r];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || rollback) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            for (int unsigned s = 0; s < NCKPT; s++) begin
                if (occ[s] && cm_hit && st[s][cm_waddr] == cm_tag) begin
                    sv[s][cm_waddr] <= 1'b1;
                    st[s][cm_waddr] <= '0;
                end
            end
            if (restore) begin
                tail <= restore_id;
                cnt  <= {1'b0, restore_id - head};
            end else begin
                // The new snapshot already includes this cycle's commit clear,
                // so its write must override the per-slot clear above.
                if (do_take) begin
                    sv[tail] <= take_valid;
                    for (int unsigned r = 0; r < NUM_REGS; r++) begin
                        st[tail][r] <= take_tag[r*ROB_W +: ROB_W];
                    end
                    tail <= tail + 1'b1;
                end
                if (do_rel) begin
                    head <= head + 1'b1;
                end
                case ({do_take, do_rel})
                    2'b10:   cnt <= cnt + 1'b1;
                    2'b01:   cnt <= cnt - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    restore_occupied: assert property (@(posedge clk) disable iff (rst)
        (restore && !rollback) |-> occ[restore_id]);

endmodule

// File: rtl/rat_ckpt.sv
// Register alias table with branch checkpoints.
// Per register: Valid, committed Value and producing ROB Tag. Register 0 is
// hardwired to zero. NREAD combinational read ports with commit bypass.
//   rollback                : full flush of all mappings and checkpoints
//   raddr/rvalid/rdata/rtag : packed read ports
//   dec_*                   : rename destination to a ROB tag
//   cm_*                    : ROB commit
//   ckpt_take/release/restore, ckpt_id/full/count : checkpoint control
module rat_ckpt
    import rat_pkg::*;
#(
    parameter  int unsigned NUM_REGS = RAT_NUM_REGS,
    parameter  int unsigned DATA_W   = RAT_DATA_W,
    parameter  int unsigned ROB_W    = RAT_ROB_W,
    parameter  int unsigned NREAD    = RAT_NREAD,
    parameter  int unsigned NCKPT    = RAT_NCKPT,
    localparam int unsigned AW       = $clog2(NUM_REGS),
    localparam int unsigned CW       = $clog2(NCKPT)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rollback,
    input  logic [NREAD*AW-1:0]     raddr,
    output logic [NREAD-1:0]        rvalid,
    output logic [NREAD*DATA_W-1:0] rdata,
    output logic [NREAD*ROB_W-1:0]  rtag,
    input  logic                    dec_we,
    input  logic [AW-1:0]           dec_waddr,
    input  logic [ROB_W-1:0]        dec_tag,
    input  logic                    cm_we,
    input  logic [AW-1:0]           cm_waddr,
    input  logic [DATA_W-1:0]       cm_data,
    input  logic [ROB_W-1:0]        cm_tag,
    input  logic                    ckpt_take,
    output logic [CW-1:0]           ckpt_id,
    input  logic                    ckpt_release,
    input  logic                    ckpt_restore,
    input  logic [CW-1:0]           ckpt_restore_id,
    output logic                    ckpt_full,
    output logic [CW:0]             ckpt_count
);

    logic [NUM_REGS-1:0]       live_valid;
    logic [ROB_W-1:0]          live_tag [NUM_REGS];
    logic [DATA_W-1:0]         value    [NUM_REGS];
    logic [NUM_REGS-1:0]       nxt_valid;
    logic [ROB_W-1:0]          nxt_tag  [NUM_REGS];
    logic [NUM_REGS*ROB_W-1:0] take_tag;
    logic [NUM_REGS-1:0]       rs_valid;
    logic [ROB_W-1:0]          rs_tag   [NUM_REGS];
    logic [NUM_REGS-1:0]       snap_valid;
    logic [NUM_REGS*ROB_W-1:0] snap_tag;
    logic                      cm_hit;
    logic                      dec_hit;
    logic                      restore_go;

    assign cm_hit     = cm_we && (cm_waddr != '0);
    assign dec_hit    = dec_we && (dec_waddr != '0);
    assign restore_go = ckpt_restore && !rollback;

    // Normal-operation next map: commit clear first, then dispatch wins.
    always_comb begin
        nxt_valid = live_valid;
        nxt_tag   = live_tag;
        if (cm_hit && live_tag[cm_waddr] == cm_tag) begin
            nxt_valid[cm_waddr] = 1'b1;
            nxt_tag[cm_waddr]   = '0;
        end
        if (dec_hit) begin
            nxt_valid[dec_waddr] = 1'b0;
            nxt_tag[dec_waddr]   = dec_tag;
        end
    end

    always_comb begin
        take_tag = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            take_tag[r*ROB_W +: ROB_W] = nxt_tag[r];
        end
    end

    // Restored map: snapshot with this cycle's commit clear folded in.
    always_comb begin
        rs_valid = snap_valid;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            rs_tag[r] = snap_tag[r*ROB_W +: ROB_W];
        end
        if (cm_hit && rs_tag[cm_waddr] == cm_tag) begin
            rs_valid[cm_waddr] = 1'b1;
            rs_tag[cm_waddr]   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            live_valid <= '1;
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                live_tag[r] <= '0;
                value[r]    <= '0;
            end
        end else begin
            if (cm_hit) begin
                value[cm_waddr] <= cm_data;
            end
            if (rollback) begin
                live_valid <= '1;
                for (int unsigned r = 0; r < NUM_REGS; r++) begin
                    live_tag[r] <= '0;
                end
            end else if (ckpt_restore) begin
                live_valid <= rs_valid;
                live_tag   <= rs_tag;
            end else begin
                live_valid <= nxt_valid;
                live_tag   <= nxt_tag;
            end
        end
    end

    always_comb begin
        rvalid = '0;
        rdata  = '0;
        rtag   = '0;
        for (int unsigned p = 0; p < NREAD; p++) begin
            if (raddr[p*AW +: AW] == '0) begin
                rvalid[p] = 1'b1;
            end else if (cm_hit && cm_waddr == raddr[p*AW +: AW]) begin
                rvalid[p]                  = 1'b1;
                rdata[p*DATA_W +: DATA_W]  = cm_data;
            end else begin
                rvalid[p]                  = live_valid[raddr[p*AW +: AW]];
                rdata[p*DATA_W +: DATA_W]  = value[raddr[p*AW +: AW]];
                rtag[p*ROB_W +: ROB_W]     = live_tag[raddr[p*AW +: AW]];
            end
        end
    end

    rat_ckpt_store #(
        .NUM_REGS (NUM_REGS),
        .ROB_W    (ROB_W),
        .NCKPT    (NCKPT)
    ) u_store (
        .clk        (clk),
        .rst        (rst),
        .rollback   (rollback),
        .take       (ckpt_take && !ckpt_restore),
        .rel        (ckpt_release && !ckpt_restore),
        .restore    (restore_go),
        .restore_id (ckpt_restore_id),
        .take_valid (nxt_valid),
        .take_tag   (take_tag),
        .cm_hit     (cm_hit),
        .cm_waddr   (cm_waddr),
        .cm_tag     (cm_tag),
        .ckpt_id    (ckpt_id),
        .full       (ckpt_full),
        .count      (ckpt_count),
        .snap_valid (snap_valid),
        .snap_tag   (snap_tag)
    );

endmodule

// File: tb/tb_rat_ckpt.sv
module tb_rat_ckpt;

    localparam int NUM_REGS = 32;
    localparam int DATA_W   = 32;
    localparam int ROB_W    = 4;
    localparam int NREAD    = 2;
    localparam int NCKPT    = 4;
    localparam int AW       = 5;
    localparam int CW       = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    rollback;
    logic [NREAD*AW-1:0]     raddr;
    logic [NREAD-1:0]        rvalid;
    logic [NREAD*DATA_W-1:0] rdata;
    logic [NREAD*ROB_W-1:0]  rtag;
    logic                    dec_we;
    logic [AW-1:0]           dec_waddr;
    logic [ROB_W-1:0]        dec_tag;
    logic                    cm_we;
    logic [AW-1:0]           cm_waddr;
    logic [DATA_W-1:0]       cm_data;
    logic [ROB_W-1:0]        cm_tag;
    logic                    ckpt_take;
    logic [CW-1:0]           ckpt_id;
    logic                    ckpt_release;
    logic                    ckpt_restore;
    logic [CW-1:0]           ckpt_restore_id;
    logic                    ckpt_full;
    logic [CW:0]             ckpt_count;

    always #5 clk = ~clk;

    rat_ckpt #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W),
        .ROB_W    (ROB_W),
        .NREAD    (NREAD),
        .NCKPT    (NCKPT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rollback        (rollback),
        .raddr           (raddr),
        .rvalid          (rvalid),
        .rdata           (rdata),
        .rtag            (rtag),
        .dec_we          (dec_we),
        .dec_waddr       (dec_waddr),
        .dec_tag         (dec_tag),
        .cm_we           (cm_we),
        .cm_waddr        (cm_waddr),
        .cm_data         (cm_data),
        .cm_tag          (cm_tag),
        .ckpt_take       (ckpt_take),
        .ckpt_id         (ckpt_id),
        .ckpt_release    (ckpt_release),
        .ckpt_restore    (ckpt_restore),
        .ckpt_restore_id (ckpt_restore_id),
        .ckpt_full       (ckpt_full),
        .ckpt_count      (ckpt_count)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: architectural map plus a queue of live checkpoint ids
    // (oldest first), each id naming a stored snapshot.
    bit          mv  [NUM_REGS];
    int          mt  [NUM_REGS];
    logic [31:0] mval[NUM_REGS];
    bit          sv  [NCKPT][NUM_REGS];
    int          st  [NCKPT][NUM_REGS];
    int          q[$];
    int          nxt;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b0; rollback = 1'b0;
        dec_we = 1'b0; dec_waddr = '0; dec_tag = '0;
        cm_we = 1'b0; cm_waddr = '0; cm_data = '0; cm_tag = '0;
        ckpt_take = 1'b0; ckpt_release = 1'b0; ckpt_restore = 1'b0; ckpt_restore_id = '0;
    endtask

    task automatic set_rd(input int a0, input int a1);
        raddr = {AW'(a1), AW'(a0)};
    endtask

    task automatic check_all();
        bit chit;
        int a;
        bit ev;
        int et;
        logic [31:0] ed;
        chit = cm_we && cm_waddr != 0;
        for (int p = 0; p < NREAD; p++) begin
            a = int'(raddr[p*AW +: AW]);
            if (a == 0) begin
                ev = 1; ed = 0; et = 0;
            end else if (chit && int'(cm_waddr) == a) begin
                ev = 1; ed = cm_data; et = 0;
            end else begin
                ev = mv[a]; ed = mval[a]; et = mt[a];
            end
            chk($sformatf("rvalid%0d", p), 64'(rvalid[p]), 64'(ev));
            chk($sformatf("rtag%0d", p), 64'(rtag[p*ROB_W +: ROB_W]), 64'(et));
            if (ev) chk($sformatf("rdata%0d", p), 64'(rdata[p*DATA_W +: DATA_W]), 64'(ed));
        end
        chk("count", 64'(ckpt_count), 64'(q.size()));
        chk("full", 64'(ckpt_full), 64'(q.size() == NCKPT));
        chk("ckpt_id", 64'(ckpt_id), 64'(nxt));
    endtask

    task automatic model_edge();
        bit chit;
        bit was_full;
        int a;
        int id;
        int idx;
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin mv[r] = 1; mt[r] = 0; mval[r] = 0; end
            q.delete();
            nxt = 0;
            return;
        end
        chit = cm_we && cm_waddr != 0;
        a = int'(cm_waddr);
        if (chit) mval[a] = cm_data;
        if (rollback) begin
            for (int r = 0; r < NUM_REGS; r++) begin mv[r] = 1; mt[r] = 0; end
            q.delete();
            nxt = 0;
        end else if (ckpt_restore) begin
            id = int'(ckpt_restore_id);
            idx = q.size();
            foreach (q[i]) if (q[i] == id) idx = i;
            for (int r = 0; r < NUM_REGS; r++) begin mv[r] = sv[id][r]; mt[r] = st[id][r]; end
            if (chit && mt[a] == int'(cm_tag)) begin mv[a] = 1; mt[a] = 0; end
            while (q.size() > idx) void'(q.pop_back());
            foreach (q[i]) if (chit && st[q[i]][a] == int'(cm_tag)) begin
                sv[q[i]][a] = 1; st[q[i]][a] = 0;
            end
            nxt = id;
        end else begin
            was_full = (q.size() == NCKPT);
            foreach (q[i]) if (chit && st[q[i]][a] == int'(cm_tag)) begin
                sv[q[i]][a] = 1; st[q[i]][a] = 0;
            end
            if (chit && mt[a] == int'(cm_tag)) begin mv[a] = 1; mt[a] = 0; end
            if (dec_we && dec_waddr != 0) begin
                mv[dec_waddr] = 0; mt[dec_waddr] = int'(dec_tag);
            end
            if (ckpt_release && q.size() > 0) void'(q.pop_front());
            if (ckpt_take && !was_full) begin
                for (int r = 0; r < NUM_REGS; r++) begin sv[nxt][r] = mv[r]; st[nxt][r] = mt[r]; end
                q.push_back(nxt);
                nxt = (nxt + 1) % NCKPT;
            end
        end
    endtask

    task automatic tick();
        #1;
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        idle();
        set_rd(5, 9);
        rst = 1'b1;
        @(posedge clk);
        model_edge();
        #1;
        idle();
        #1;
        // Reset state
        chk("rst_rvalid", 64'(rvalid), 64'(2'b11));
        chk("rst_rdata", 64'(rdata), 64'(0));
        chk("rst_rtag", 64'(rtag), 64'(0));
        chk("rst_count", 64'(ckpt_count), 64'(0));
        chk("rst_id", 64'(ckpt_id), 64'(0));
        chk("rst_full", 64'(ckpt_full), 64'(0));
        tick();

        // Rename then commit with bypass
        dec_we = 1; dec_waddr = 5; dec_tag = 3;
        tick();
        idle();
        cm_we = 1; cm_waddr = 5; cm_tag = 3; cm_data = 32'hDEAD;
        #1;
        chk("bypass_valid", 64'(rvalid[0]), 64'(1));
        chk("bypass_data", 64'(rdata[31:0]), 64'(32'hDEAD));
        tick();
        idle();
        #1;
        chk("commit_valid", 64'(rvalid[0]), 64'(1));
        chk("commit_data", 64'(rdata[31:0]), 64'(32'hDEAD));
        tick();

        // Stale commit must not clear a newer rename
        dec_we = 1; dec_waddr = 5; dec_tag = 3;
        tick();
        dec_tag = 7;
        tick();
        idle();
        cm_we = 1; cm_waddr = 5; cm_tag = 3; cm_data = 32'h11;
        tick();
        idle();
        #1;
        chk("stale_valid", 64'(rvalid[0]), 64'(0));
        chk("stale_tag", 64'(rtag[3:0]), 64'(7));
        chk("stale_value", 64'(rdata[31:0]), 64'(32'h11));
        cm_we = 1; cm_waddr = 5; cm_tag = 7; cm_data = 32'h12;
        tick();

        // Checkpoint restore
        idle();
        set_rd(2, 6);
        dec_we = 1; dec_waddr = 2; dec_tag = 1; ckpt_take = 1;
        #1;
        chk("take_id0", 64'(ckpt_id), 64'(0));
        tick();
        idle();
        dec_we = 1; dec_waddr = 2; dec_tag = 4;
        tick();
        dec_waddr = 6; dec_tag = 5;
        tick();
        idle();
        cm_we = 1; cm_waddr = 2; cm_tag = 1; cm_data = 32'h77;
        tick();
        idle();
        ckpt_restore = 1; ckpt_restore_id = 0;
        tick();
        idle();
        #1;
        chk("restore_valid", 64'(rvalid), 64'(2'b11));
        chk("restore_data", 64'(rdata[31:0]), 64'(32'h77));
        chk("restore_count", 64'(ckpt_count), 64'(0));
        tick();

        // Full and wrap-around
        for (int i = 0; i < NCKPT; i++) begin
            ckpt_take = 1;
            #1;
            chk("fill_id", 64'(ckpt_id), 64'(i));
            tick();
        end
        idle();
        #1;
        chk("full_flag", 64'(ckpt_full), 64'(1));
        chk("full_count", 64'(ckpt_count), 64'(4));
        ckpt_take = 1;
        tick();
        idle();
        #1;
        chk("ignored_count", 64'(ckpt_count), 64'(4));
        chk("ignored_id", 64'(ckpt_id), 64'(0));
        ckpt_release = 1;
        tick();
        tick();
        idle();
        ckpt_take = 1;
        #1;
        chk("wrap_id0", 64'(ckpt_id), 64'(0));
        tick();
        #1;
        chk("wrap_id1", 64'(ckpt_id), 64'(1));
        tick();
        idle();
        #1;
        chk("wrap_count", 64'(ckpt_count), 64'(4));
        chk("wrap_full", 64'(ckpt_full), 64'(1));

        // Commit on r0 is ignored
        set_rd(0, 0);
        cm_we = 1; cm_waddr = 0; cm_data = 32'h55; cm_tag = 0;
        #1;
        chk("r0_bypass", 64'(rdata), 64'(0));
        tick();
        idle();
        #1;
        chk("r0_data", 64'(rdata), 64'(0));
        chk("r0_valid", 64'(rvalid), 64'(2'b11));

        // Rollback with three checkpoints and a pending rename
        ckpt_release = 1;
        tick();
        idle();
        dec_we = 1; dec_waddr = 9; dec_tag = 2;
        tick();
        idle();
        set_rd(9, 9);
        #1;
        chk("pend_valid", 64'(rvalid[0]), 64'(0));
        chk("pend_count", 64'(ckpt_count), 64'(3));
        rollback = 1;
        tick();
        idle();
        #1;
        chk("rb_count", 64'(ckpt_count), 64'(0));
        chk("rb_valid", 64'(rvalid), 64'(2'b11));
        chk("rb_tag", 64'(rtag), 64'(0));
        tick();

        // Randomised traffic against the model
        for (int n = 0; n < 600; n++) begin
            idle();
            dec_we    = ($urandom % 2) == 0;
            dec_waddr = AW'($urandom % 8);
            dec_tag   = ROB_W'($urandom);
            cm_we     = ($urandom % 3) != 0;
            cm_waddr  = AW'($urandom % 8);
            cm_tag    = (($urandom % 4) != 0) ? ROB_W'(mt[cm_waddr]) : ROB_W'($urandom);
            cm_data   = $urandom;
            ckpt_take    = ($urandom % 3) == 0;
            ckpt_release = ($urandom % 4) == 0;
            rollback     = ($urandom % 60) == 0;
            if (q.size() > 0 && ($urandom % 10) == 0) begin
                ckpt_restore    = 1;
                ckpt_restore_id = CW'(q[$urandom % q.size()]);
            end
            set_rd($urandom % 8, $urandom % 8);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
